sd_cal_sequencer: RTL and testbench

//  Sequences two-point self-calibration of the sigma-delta ADC path ahead of the calibration datapath.
//  Per cal_start it switches the input mux to the zero reference, then to the full-scale reference.
//  In each phase it discards settling samples, then averages 2^LOG2_N samples.
//  It produces offset (zero average) and gain (REF_CODE / span, Q2.14), which configure the downstream scaler.

---
 rtl/sd_cal_pkg.sv | 35 +++
 rtl/sd_cal_sequencer_if.sv | 33 +++
 rtl/sd_cal_divider.sv | 84 ++++++++
 rtl/sd_cal_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_sd_cal_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_cal_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : sd_cal_pkg
//  Purpose   : Shared types and constants for the sigma-delta two-point
//              calibration sequencer and its divider.
//  Revision  : 1.0  initial release
// ============================================================================
package sd_cal_pkg;

  // Sequencer states: zero-reference phase, full-scale phase, divide, publish
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    Z_SETTLE = 3'd1,
    Z_ACC    = 3'd2,
    R_SETTLE = 3'd3,
    R_ACC    = 3'd4,
    DIVIDE   = 3'd5,
    DONE     = 3'd6
  } cal_state_t;

  // Input mux selections
  localparam logic [1:0] MUX_NORMAL = 2'b00;
  localparam logic [1:0] MUX_ZERO   = 2'b01;
  localparam logic [1:0] MUX_REF    = 2'b10;

  // Gain is Q2.14: 1.0 is 16'h4000
  localparam logic [15:0] GAIN_ONE       = 16'h4000;
  localparam int          GAIN_FRAC_BITS = 14;

  // Divider geometry: {24-bit reference code, 14 fraction bits} / 25-bit span
  localparam int DIV_DVD_W = 24 + GAIN_FRAC_BITS;
  localparam int DIV_DSR_W = 25;

endpackage
`default_nettype wire

// File: rtl/sd_cal_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface : sd_cal_sequencer_if
//  Purpose   : Control, sample and coefficient signals of the calibration
//              sequencer. master drives requests and samples, slave is the
//              sequencer itself.
//  Revision  : 1.0  initial release
// ============================================================================
interface sd_cal_sequencer_if;

  logic        cal_start;
  logic        cal_abort;
  logic        adc_valid;
  logic [23:0] adc_in;
  logic [1:0]  mux_sel;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_error;
  logic [23:0] offset_out;
  logic [15:0] gain_out;

  modport master (
    output cal_start, cal_abort, adc_valid, adc_in,
    input  mux_sel, cal_busy, cal_done, cal_error, offset_out, gain_out
  );

  modport slave (
    input  cal_start, cal_abort, adc_valid, adc_in,
    output mux_sel, cal_busy, cal_done, cal_error, offset_out, gain_out
  );

endinterface
`default_nettype wire

// File: rtl/sd_cal_divider.sv
`default_nettype none
// ============================================================================
//  Module    : sd_cal_divider
//  Purpose   : Restoring divider, one quotient bit per clock. Produces a
//              16-bit quotient that saturates to 16'hFFFF when the true
//              quotient does not fit.
//  Revision  : 1.0  initial release
// ============================================================================
module sd_cal_divider
  import sd_cal_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 flush,
  input  logic [DIV_DVD_W-1:0] dividend,
  input  logic [DIV_DSR_W-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          quotient
);

  logic [DIV_DVD_W-1:0] dvd;
  logic [DIV_DSR_W-1:0] dsr;
  logic [DIV_DSR_W-1:0] rem;
  logic [15:0]          quo;
  logic                 ovf;
  logic [5:0]           remaining;

  logic [DIV_DSR_W:0]   rem_shift;
  logic                 ge;
  logic [DIV_DSR_W-1:0] rem_diff;
  logic [15:0]          quo_next;
  logic                 ovf_next;

  // Remainder stays below the divisor, so the true difference fits 25 bits
  assign rem_shift = {rem, dvd[DIV_DVD_W-1]};
  assign ge        = rem_shift >= {1'b0, dsr};
  assign rem_diff  = rem_shift[DIV_DSR_W-1:0] - dsr;
  assign quo_next  = {quo[14:0], ge};
  // Any 1 shifted past bit 15 means the quotient exceeds 16 bits
  assign ovf_next  = ovf | quo[15];

  // Iterate one quotient bit per cycle; publish saturated result on the last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      quo       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= GAIN_ONE;
    end else begin
      done <= 1'b0;
      if (flush) begin
        busy <= 1'b0;
      end else if (start) begin
        dvd       <= dividend;
        dsr       <= divisor;
        rem       <= '0;
        quo       <= '0;
        ovf       <= 1'b0;
        remaining <= 6'(DIV_DVD_W);
        busy      <= 1'b1;
      end else if (busy) begin
        dvd       <= {dvd[DIV_DVD_W-2:0], 1'b0};
        rem       <= ge ? rem_diff : rem_shift[DIV_DSR_W-1:0];
        quo       <= quo_next;
        ovf       <= ovf_next;
        remaining <= remaining - 6'd1;
        if (remaining == 6'd1) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= ovf_next ? 16'hFFFF : quo_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_cal_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : sd_cal_sequencer
//  Purpose   : Two-point self-calibration of the sigma-delta ADC path.
//              Averages the zero and full-scale references, then derives
//              offset and a Q2.14 gain (REF_CODE / span) for the scaler.
//  Revision  : 1.0  initial release
// ============================================================================
module sd_cal_sequencer
  import sd_cal_pkg::*;
#(
  parameter int          LOG2_N   = 4,
  parameter int          SETTLE   = 2,
  parameter logic [23:0] REF_CODE = 24'h400000,
  parameter logic [23:0] MIN_SPAN = 24'h001000,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  sd_cal_sequencer_if.slave  bus
);

  localparam int             ACC_W       = 24 + LOG2_N;
  localparam logic [8:0]     SETTLE_LAST = 9'(SETTLE - 1);
  localparam logic [8:0]     ACC_LAST    = 9'((1 << LOG2_N) - 1);
  localparam logic [DIV_DVD_W-1:0] DIVIDEND = {REF_CODE, {GAIN_FRAC_BITS{1'b0}}};

  cal_state_t        state;
  logic [1:0]        mux_sel;
  logic              cal_busy;
  logic              cal_done;
  logic              cal_error;
  logic [23:0]       offset_out;
  logic [15:0]       gain_out;
  logic [23:0]       zero_avg;
  logic [ACC_W-1:0]  acc;
  logic [8:0]        cnt;
  logic [15:0]       tcnt;

  logic [ACC_W-1:0]  acc_next;
  logic [23:0]       avg_now;
  logic [24:0]       span;
  logic              span_ok;
  logic              in_wait;
  logic              timeout_hit;
  logic              acc_last;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [15:0]       div_q;

  assign acc_next    = acc + ACC_W'(bus.adc_in);
  // Average including the sample arriving this cycle, truncated
  assign avg_now     = acc_next[LOG2_N +: 24];
  // Signed 25-bit span; a set sign bit means ref fell below zero
  assign span        = {1'b0, avg_now} - {1'b0, zero_avg};
  assign span_ok     = !span[24] && (span[23:0] >= MIN_SPAN);
  assign in_wait     = state inside {Z_SETTLE, Z_ACC, R_SETTLE, R_ACC};
  assign timeout_hit = in_wait && !bus.adc_valid && (tcnt == TIMEOUT - 16'd1);
  assign acc_last    = bus.adc_valid && (cnt == ACC_LAST);
  assign div_start   = (state == R_ACC) && acc_last && span_ok && !bus.cal_abort;

  sd_cal_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .flush    (bus.cal_abort),
    .dividend (DIVIDEND),
    .divisor  (span),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // Calibration FSM with registered mux, status and coefficient outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mux_sel    <= MUX_NORMAL;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_error  <= 1'b0;
      offset_out <= '0;
      gain_out   <= GAIN_ONE;
      zero_avg   <= '0;
      acc        <= '0;
      cnt        <= '0;
      tcnt       <= '0;
    end else begin
      cal_done <= 1'b0;
      if (in_wait) begin
        tcnt <= bus.adc_valid ? 16'd0 : tcnt + 16'd1;
      end

      if (bus.cal_abort) begin
        state    <= IDLE;
        mux_sel  <= MUX_NORMAL;
        cal_busy <= 1'b0;
      end else if (timeout_hit) begin
        state     <= IDLE;
        mux_sel   <= MUX_NORMAL;
        cal_busy  <= 1'b0;
        cal_error <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.cal_start) begin
              state     <= (SETTLE == 0) ? Z_ACC : Z_SETTLE;
              mux_sel   <= MUX_ZERO;
              cal_busy  <= 1'b1;
              cal_error <= 1'b0;
              cnt       <= '0;
              tcnt      <= '0;
              acc       <= '0;
            end
          end
          Z_SETTLE: begin
            if (bus.adc_valid) begin
              if (cnt == SETTLE_LAST) begin
                cnt   <= '0;
                state <= Z_ACC;
              end else begin
                cnt <= cnt + 9'd1;
              end
            end
          end
          Z_ACC: begin
            if (bus.adc_valid) begin
              acc <= acc_next;
              if (acc_last) begin
                zero_avg <= avg_now;
                acc      <= '0;
                cnt      <= '0;
                mux_sel  <= MUX_REF;
                state    <= (SETTLE == 0) ? R_ACC : R_SETTLE;
              end else begin
                cnt <= cnt + 9'd1;
              end
            end
          end
          R_SETTLE: begin
            if (bus.adc_valid) begin
              if (cnt == SETTLE_LAST) begin
                cnt   <= '0;
                state <= R_ACC;
              end else begin
                cnt <= cnt + 9'd1;
              end
            end
          end
          R_ACC: begin
            if (bus.adc_valid) begin
              acc <= acc_next;
              if (acc_last) begin
                cnt     <= '0;
                mux_sel <= MUX_NORMAL;
                if (span_ok) begin
                  state <= DIVIDE;
                end else begin
                  state     <= IDLE;
                  cal_busy  <= 1'b0;
                  cal_error <= 1'b1;
                end
              end else begin
                cnt <= cnt + 9'd1;
              end
            end
          end
          DIVIDE: begin
            if (div_done) begin
              state      <= DONE;
              offset_out <= zero_avg;
              gain_out   <= div_q;
              cal_done   <= 1'b1;
            end else if (!div_busy) begin
              // Divider idle without a result: never expected, fail safe
              state     <= IDLE;
              cal_busy  <= 1'b0;
              cal_error <= 1'b1;
            end
          end
          DONE: begin
            state    <= IDLE;
            cal_busy <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            mux_sel  <= MUX_NORMAL;
            cal_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mux_sel    = mux_sel;
  assign bus.cal_busy   = cal_busy;
  assign bus.cal_done   = cal_done;
  assign bus.cal_error  = cal_error;
  assign bus.offset_out = offset_out;
  assign bus.gain_out   = gain_out;

endmodule
`default_nettype wire

// File: tb/tb_sd_cal_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_sd_cal_sequencer
//  Purpose   : Self-checking bench for sd_cal_sequencer with a sum/divide
//              reference model of the calibration result.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_sd_cal_sequencer;

  localparam int     NS       = 16;
  localparam int     SETTLE   = 2;
  localparam longint REF_CODE = 64'h400000;
  localparam longint MIN_SPAN = 64'h1000;
  localparam int     TIMEOUT  = 100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sd_cal_sequencer_if bus();

  sd_cal_sequencer #(
    .LOG2_N   (4),
    .SETTLE   (SETTLE),
    .REF_CODE (24'h400000),
    .MIN_SPAN (24'h001000),
    .TIMEOUT  (16'd100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int     compared   = 0;
  int     mismatched = 0;
  int     done_cnt   = 0;
  longint m_off      = 0;
  longint m_gain     = 64'h4000;
  bit     m_err      = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.cal_done === 1'b1) done_cnt++;
  endtask

  task automatic feed(input logic [23:0] v, input bit gap);
    bus.adc_valid = 1'b1;
    bus.adc_in    = v;
    tick();
    bus.adc_valid = 1'b0;
    bus.adc_in    = 24'($urandom);
    if (gap) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic start_cal();
    bus.cal_start = 1'b1;
    tick();
    bus.cal_start = 1'b0;
    m_err = 1'b0;
  endtask

  function automatic longint model_gain(input longint span);
    longint q;
    q = (REF_CODE << 14) / span;
    return (q > 65535) ? 65535 : q;
  endfunction

  task automatic check_coeffs(input string tag);
    chk({tag, "_offset"}, bus.offset_out, m_off);
    chk({tag, "_gain"},   bus.gain_out,   m_gain);
    chk({tag, "_error"},  bus.cal_error,  m_err);
  endtask

  task automatic run_cal(input logic [23:0] zb, input logic [23:0] rb, input int noise,
                         input bit garbage, input bit poke);
    longint      zsum = 0;
    longint      rsum = 0;
    longint      span;
    int          d0;
    int          cyc = 0;
    logic [23:0] v;
    start_cal();
    chk("busy_after_start", bus.cal_busy, 1);
    chk("mux_zero", bus.mux_sel, 2'b01);
    chk("err_cleared", bus.cal_error, 0);
    d0 = done_cnt;
    for (int s = 0; s < SETTLE; s++) feed(garbage ? 24'($urandom) : zb, 1'b1);
    for (int i = 0; i < NS; i++) begin
      v = zb + 24'($urandom_range(0, noise));
      zsum += v;
      if (poke && i == 7) bus.cal_start = 1'b1;
      feed(v, 1'b1);
      bus.cal_start = 1'b0;
    end
    chk("mux_ref", bus.mux_sel, 2'b10);
    for (int s = 0; s < SETTLE; s++) feed(garbage ? 24'($urandom) : rb, 1'b1);
    for (int i = 0; i < NS; i++) begin
      v = rb + 24'($urandom_range(0, noise));
      rsum += v;
      feed(v, 1'b1);
    end
    chk("no_early_done", done_cnt - d0, 0);
    span = (rsum >> 4) - (zsum >> 4);
    while (cyc < 100 && bus.cal_busy === 1'b1 && done_cnt == d0) begin
      tick();
      cyc++;
    end
    if (span >= MIN_SPAN) begin
      m_off  = zsum >> 4;
      m_gain = model_gain(span);
      chk("done_pulse", done_cnt - d0, 1);
    end else begin
      m_err = 1'b1;
      chk("done_pulse", done_cnt - d0, 0);
    end
    check_coeffs("result");
    tick();
    chk("idle_busy", bus.cal_busy, 0);
    chk("idle_mux", bus.mux_sel, 2'b00);
  endtask

  initial begin
    int          k;
    int          d0;
    logic [23:0] zb;
    logic [23:0] rb;
    bus.cal_start = 1'b0;
    bus.cal_abort = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_in    = '0;

    // Reset values
    repeat (2) tick();
    chk("rst_mux", bus.mux_sel, 2'b00);
    chk("rst_busy", bus.cal_busy, 0);
    chk("rst_done", bus.cal_done, 0);
    check_coeffs("rst");
    reset = 1'b0;
    tick();

    // Unity gain
    run_cal(24'h000100, 24'h400100, 0, 1'b0, 1'b0);
    chk("t1_gain", bus.gain_out, 16'h4000);
    chk("t1_offset", bus.offset_out, 24'h000100);

    // Gain of 2.0
    run_cal(24'h000100, 24'h200100, 0, 1'b0, 1'b0);
    chk("t2_gain", bus.gain_out, 16'h8000);
    chk("t2_error", bus.cal_error, 0);

    // Zero span fails, coefficients retained
    run_cal(24'h123456, 24'h123456, 0, 1'b0, 1'b0);
    chk("t3_error", bus.cal_error, 1);
    chk("t3_gain_kept", bus.gain_out, 16'h8000);

    // Abort together with start in IDLE: start is not accepted
    bus.cal_start = 1'b1;
    bus.cal_abort = 1'b1;
    tick();
    bus.cal_start = 1'b0;
    bus.cal_abort = 1'b0;
    chk("abort_start_busy", bus.cal_busy, 0);
    chk("abort_start_err", bus.cal_error, m_err);
    tick();
    chk("abort_start_busy2", bus.cal_busy, 0);

    // Saturating gain, with garbage settle samples, then clean with a stray start
    run_cal(24'h000100, 24'h010100, 0, 1'b1, 1'b0);
    chk("t4_sat_gain", bus.gain_out, 16'hFFFF);
    run_cal(24'h000100, 24'h010100, 0, 1'b0, 1'b1);
    chk("t4_sat_gain_clean", bus.gain_out, 16'hFFFF);

    // Randomized calibrations
    for (int it = 0; it < 6; it++) begin
      zb = 24'($urandom_range(0, 32'h100000));
      if (it % 3 == 2) rb = zb + 24'($urandom_range(0, 32'h1400));
      else             rb = zb + 24'($urandom_range(32'h1000, 32'h300000));
      if (it == 4)     rb = zb >> 1;
      run_cal(zb, rb, int'($urandom_range(0, 255)), bit'(it & 1), 1'b0);
    end

    // Timeout while accumulating the zero phase
    start_cal();
    for (int s = 0; s < SETTLE; s++) feed(24'h000100, 1'b1);
    for (int i = 0; i < 5; i++) feed(24'h000100, i < 4);
    for (k = 1; k <= 150; k++) begin
      tick();
      if (bus.cal_error === 1'b1) break;
    end
    chk("timeout_cycle", k, TIMEOUT);
    chk("timeout_busy", bus.cal_busy, 0);
    chk("timeout_mux", bus.mux_sel, 2'b00);
    m_err = 1'b1;
    check_coeffs("timeout");
    run_cal(24'h000200, 24'h300200, 16, 1'b0, 1'b0);

    // Abort in the middle of the full-scale accumulation
    start_cal();
    for (int s = 0; s < SETTLE; s++) feed(24'h000050, 1'b1);
    for (int i = 0; i < NS; i++) feed(24'h000050, 1'b1);
    for (int s = 0; s < SETTLE; s++) feed(24'h100050, 1'b1);
    for (int i = 0; i < 5; i++) feed(24'h100050, 1'b1);
    chk("pre_abort_mux", bus.mux_sel, 2'b10);
    d0 = done_cnt;
    bus.cal_abort = 1'b1;
    tick();
    bus.cal_abort = 1'b0;
    chk("abort_busy", bus.cal_busy, 0);
    chk("abort_mux", bus.mux_sel, 2'b00);
    check_coeffs("abort");
    repeat (60) tick();
    chk("abort_no_done", done_cnt - d0, 0);

    // Asynchronous reset mid zero accumulation
    start_cal();
    for (int s = 0; s < SETTLE; s++) feed(24'h000300, 1'b1);
    for (int i = 0; i < 5; i++) feed(24'h000300, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    m_off  = 0;
    m_gain = 64'h4000;
    m_err  = 1'b0;
    chk("async_rst_mux", bus.mux_sel, 2'b00);
    chk("async_rst_busy", bus.cal_busy, 0);
    chk("async_rst_done", bus.cal_done, 0);
    check_coeffs("async_rst");
    tick();
    reset = 1'b0;
    tick();
    run_cal(24'h000400, 24'h200400, 64, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
